// File: rtl/rsa_exp_launch.sv
// Request-side launcher for the modular-exponentiation engine.
// It finds the exponent MSB by a serial scan, pulses exp_start and holds the operands until the response is taken.
module rsa_exp_launch #(
    parameter int BITLEN     = 256,
    parameter int LOG_BITLEN = 8,
    parameter int CNT_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BITLEN-1:0]     req_e,
    input  logic [BITLEN-1:0]     req_n,
    input  logic [LOG_BITLEN:0]   req_mp_count,
    output logic                  exp_start,
    output logic [BITLEN-1:0]     exp_e,
    output logic [LOG_BITLEN-1:0] exp_e_idx,
    output logic [BITLEN-1:0]     exp_n,
    output logic [LOG_BITLEN:0]   exp_mp_count,
    input  logic                  exp_stop,
    input  logic [BITLEN-1:0]     exp_ans,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITLEN-1:0]     rsp_ans,
    output logic                  rsp_err,
    output logic [CNT_BITS-1:0]   rsp_cycles,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [LOG_BITLEN-1:0] idx;
    logic                  stop_q;
    logic                  accept;
    logic                  stop_rise;
    logic                  scan_hit;
    logic                  scan_last;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == {CNT_BITS{1'b1}}) ? v : v + CNT_BITS'(1);
    endfunction

    assign accept    = req_valid && (state == IDLE);
    assign stop_rise = exp_stop && !stop_q;
    // Index 0 is never a valid MSB: the engine needs e >= 2.
    assign scan_hit  = exp_e[idx] && (idx != '0);
    assign scan_last = (idx == LOG_BITLEN'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    state_nxt = START;
                end else if (scan_last) begin
                    state_nxt = RESP;
                end
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (stop_rise) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        exp_start = (state == START);
        rsp_valid = (state == RESP);
    end

    // Operand, scan and response registers; everything here is cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_e        <= '0;
            exp_n        <= '0;
            exp_mp_count <= '0;
            exp_e_idx    <= '0;
            idx          <= '0;
            rsp_ans      <= '0;
            rsp_err      <= 1'b0;
            rsp_cycles   <= '0;
            stop_q       <= 1'b0;
        end else begin
            stop_q <= exp_stop;
            if (accept) begin
                exp_e        <= req_e;
                exp_n        <= req_n;
                exp_mp_count <= req_mp_count;
                idx          <= LOG_BITLEN'(BITLEN - 1);
                rsp_cycles   <= '0;
            end
            if (state == SCAN) begin
                if (scan_hit) begin
                    exp_e_idx <= idx;
                end else if (scan_last) begin
                    rsp_err <= 1'b1;
                    rsp_ans <= '0;
                end else begin
                    idx <= idx - LOG_BITLEN'(1);
                end
            end
            if (state == WAIT) begin
                rsp_cycles <= sat_inc(rsp_cycles);
                if (stop_rise) begin
                    rsp_ans <= exp_ans;
                    rsp_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rsa_exp_launch.sv
// Directed bench for rsa_exp_launch at BITLEN=16: scan timing, e<2 rejection,
// backpressure, stop-edge handling and mid-run reset.
module tb_rsa_exp_launch;

    localparam int BITLEN     = 16;
    localparam int LOG_BITLEN = 4;
    localparam int CNT_BITS   = 32;

    logic                  clk;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [BITLEN-1:0]     req_e;
    logic [BITLEN-1:0]     req_n;
    logic [LOG_BITLEN:0]   req_mp_count;
    logic                  exp_start;
    logic [BITLEN-1:0]     exp_e;
    logic [LOG_BITLEN-1:0] exp_e_idx;
    logic [BITLEN-1:0]     exp_n;
    logic [LOG_BITLEN:0]   exp_mp_count;
    logic                  exp_stop;
    logic [BITLEN-1:0]     exp_ans;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [BITLEN-1:0]     rsp_ans;
    logic                  rsp_err;
    logic [CNT_BITS-1:0]   rsp_cycles;
    logic                  busy;

    int cyc;
    int n_cmp;
    int n_bad;
    int t0;

    rsa_exp_launch #(
        .BITLEN    (BITLEN),
        .LOG_BITLEN(LOG_BITLEN),
        .CNT_BITS  (CNT_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_e       (req_e),
        .req_n       (req_n),
        .req_mp_count(req_mp_count),
        .exp_start   (exp_start),
        .exp_e       (exp_e),
        .exp_e_idx   (exp_e_idx),
        .exp_n       (exp_n),
        .exp_mp_count(exp_mp_count),
        .exp_stop    (exp_stop),
        .exp_ans     (exp_ans),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_ans     (rsp_ans),
        .rsp_err     (rsp_err),
        .rsp_cycles  (rsp_cycles),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Requests with e < 2 must be rejected after the full scan without launching the engine.
    task automatic run_small(input logic [BITLEN-1:0] e, input string tag);
        int ts;
        req_e     = e;
        req_valid = 1'b1;
        chk({tag, "_req_ready"}, req_ready, 1);
        ts = cyc;
        tick();
        req_valid = 1'b0;
        while (cyc < ts + 16) begin
            chk({tag, "_no_start"}, exp_start, 0);
            chk({tag, "_no_valid"}, rsp_valid, 0);
            tick();
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_err"}, rsp_err, 1);
        chk({tag, "_ans"}, rsp_ans, 0);
        chk({tag, "_cycles"}, rsp_cycles, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_back_idle"}, req_ready, 1);
    endtask

    initial begin
        cyc          = 0;
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_e        = '0;
        req_n        = '0;
        req_mp_count = '0;
        exp_stop     = 1'b0;
        exp_ans      = '0;
        rsp_ready    = 1'b0;

        tick();
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", exp_start, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_exp_e", exp_e, 0);
        chk("rst_cycles", rsp_cycles, 0);
        chk("rst_err", rsp_err, 0);
        rst = 1'b0;
        tick();

        // e=0x0011: MSB at 4, start at T+13, stop rises at T+40 for two cycles
        req_e        = 16'h0011;
        req_n        = 16'hFFF1;
        req_mp_count = 5'd5;
        req_valid    = 1'b1;
        chk("t1_req_ready", req_ready, 1);
        t0 = cyc;
        tick();
        req_valid = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_req_ready_low", req_ready, 0);
        chk("t1_exp_e", exp_e, 32'h0011);
        chk("t1_exp_n", exp_n, 32'hFFF1);
        chk("t1_mp", exp_mp_count, 5);
        while (cyc < t0 + 40) begin
            chk("t1_start", exp_start, (cyc == t0 + 13));
            chk("t1_no_valid", rsp_valid, 0);
            if (cyc == t0 + 13) chk("t1_idx", exp_e_idx, 4);
            exp_stop = (cyc == t0 + 5);
            tick();
        end
        exp_stop = 1'b1;
        exp_ans  = 16'h1234;
        tick();
        exp_ans = 16'hDEAD;
        chk("t1_valid", rsp_valid, 1);
        chk("t1_ans", rsp_ans, 32'h1234);
        chk("t1_err", rsp_err, 0);
        chk("t1_cycles", rsp_cycles, 27);
        tick();
        exp_stop = 1'b0;

        // backpressure with the next request already waiting
        req_e        = 16'h8001;
        req_n        = 16'h00F7;
        req_mp_count = 5'd3;
        req_valid    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_ans", rsp_ans, 32'h1234);
            chk("bp_cycles", rsp_cycles, 27);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_exp_e", exp_e, 32'h0011);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_req_ready_after", req_ready, 1);
        chk("bp_valid_after", rsp_valid, 0);

        // e=0x8001: MSB at 15, start at T+2; 3-cycle stop rising at T+5
        t0 = cyc;
        tick();
        req_valid = 1'b0;
        chk("t2_exp_e", exp_e, 32'h8001);
        chk("t2_no_start", exp_start, 0);
        tick();
        chk("t2_start", exp_start, 1);
        chk("t2_idx", exp_e_idx, 15);
        tick();
        chk("t2_start_end", exp_start, 0);
        tick();
        tick();
        chk("t2_wait", rsp_valid, 0);
        exp_stop = 1'b1;
        exp_ans  = 16'hBEEF;
        tick();
        exp_ans = 16'h1111;
        chk("t2_valid", rsp_valid, 1);
        chk("t2_ans", rsp_ans, 32'hBEEF);
        chk("t2_cycles", rsp_cycles, 3);
        tick();
        chk("t2_ans_hold", rsp_ans, 32'hBEEF);
        tick();
        exp_stop  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t2_back_idle", req_ready, 1);

        run_small(16'h0001, "e1");
        run_small(16'h0000, "e0");

        // reset in the middle of WAIT, then a stray stop while idle
        req_e     = 16'h0011;
        req_valid = 1'b1;
        t0 = cyc;
        tick();
        req_valid = 1'b0;
        while (cyc < t0 + 20) tick();
        chk("mr_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_req_ready", req_ready, 1);
        chk("mr_valid", rsp_valid, 0);
        chk("mr_exp_e", exp_e, 0);
        chk("mr_idx", exp_e_idx, 0);
        chk("mr_cycles", rsp_cycles, 0);
        #1;
        rst = 1'b0;
        tick();
        exp_stop = 1'b1;
        exp_ans  = 16'h5555;
        tick();
        chk("mr_stray_valid", rsp_valid, 0);
        chk("mr_stray_busy", busy, 0);
        tick();
        exp_stop = 1'b0;
        chk("mr_stray_valid2", rsp_valid, 0);

        // normal run after reset
        req_e     = 16'h8001;
        req_valid = 1'b1;
        t0 = cyc;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pr_start", exp_start, 1);
        tick();
        tick();
        exp_stop = 1'b1;
        exp_ans  = 16'h0BAD;
        tick();
        chk("pr_valid", rsp_valid, 1);
        chk("pr_ans", rsp_ans, 32'h0BAD);
        chk("pr_cycles", rsp_cycles, 2);
        exp_stop  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("pr_back_idle", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rsa_exp_launch.md
# rsa_exp_launch

Request-side front end for the modular-exponentiation engine (`mon_exp`).
- Accepts one exponentiation request (exponent, modulus, Montgomery word count) over a valid/ready handshake.
- Scans the exponent serially to find its most-significant set bit.
- Launches the engine with a one-cycle start pulse, holds all operands stable for the whole run, and returns the result (or an error) over a valid/ready response handshake.
- Rejects exponents below 2, which the engine cannot process.

## Interface
- BITLEN, 256, operand width in bits
- LOG_BITLEN, 8, log2(BITLEN)
- CNT_BITS, 32, width of the run-cycle counter
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_e  in  BITLEN  exponent
- req_n  in  BITLEN  modulus
- req_mp_count  in  LOG_BITLEN+1  Montgomery iteration count
- exp_start  out  1  one-cycle launch pulse to the engine
- exp_e  out  BITLEN  registered exponent
- exp_e_idx  out  LOG_BITLEN  index of the exponent MSB
- exp_n  out  BITLEN  registered modulus
- exp_mp_count  out  LOG_BITLEN+1  registered count
- exp_stop  in  1  engine done flag; may stay high for more than one cycle
- exp_ans  in  BITLEN  engine result; valid in the cycle of the exp_stop rising edge
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_ans  out  BITLEN  result; 0 when rsp_err=1
- rsp_err  out  1  1 = exponent < 2, engine not run
- rsp_cycles  out  CNT_BITS  cycles spent in WAIT (saturating)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SCAN, START, WAIT, RESP.
- IDLE
  - On req_valid && req_ready: register req_e, req_n, req_mp_count into exp_e, exp_n, exp_mp_count.
  - Set idx = BITLEN-1, clear rsp_cycles, go to SCAN.
- SCAN (one bit per cycle)
  - If exp_e[idx]=1 and idx≥1: exp_e_idx ← idx, go to START.
  - Else if idx=1 (bit 1 clear, so e<2): rsp_err ← 1, rsp_ans ← 0, go to RESP.
  - Else idx ← idx-1.
- START
  - exp_start=1 for exactly this cycle, go to WAIT.
- WAIT
  - rsp_cycles increments every cycle, saturating at all-ones.
  - On an exp_stop rising edge: rsp_ans ← exp_ans, rsp_err ← 0, go to RESP.
  - Edge detection uses a registered copy of exp_stop. A stop level that was already high on entry to WAIT does not count as an edge.
- RESP
  - rsp_valid=1, with rsp_ans, rsp_err and rsp_cycles held stable.
  - On rsp_ready: go to IDLE.
- exp_e, exp_n, exp_mp_count and exp_e_idx change only on request acceptance (exp_e_idx also at the SCAN hit). They are stable from START through RESP.
- exp_stop edges seen in IDLE, SCAN or RESP are ignored.
- req_valid outside IDLE is not consumed; the upstream requester holds it.

## Timing
- Reset, applied asynchronously, forces:
  - state = IDLE
  - exp_start=0, rsp_valid=0, busy=0, req_ready=1 (combinational from IDLE)
  - exp_e/exp_n/exp_mp_count/exp_e_idx/rsp_ans/rsp_cycles = 0, rsp_err=0, stored exp_stop copy = 0
- Reset mid-run
  - Returns the FSM to IDLE immediately.
  - The engine has no reset; the system must also quiesce it. A later stray exp_stop is ignored in IDLE.
- Accept in cycle T; the exponent MSB is at index m ≥ 1.
  - SCAN tests index k in cycle T+1+(BITLEN-1-k).
  - exp_start is high in cycle T+BITLEN-m+1.
- e<2: rsp_valid rises in cycle T+BITLEN.
- exp_stop rises in cycle S during WAIT: rsp_valid=1 from S+1. rsp_cycles = S - (start cycle).
- Response accepted in cycle R: req_ready=1 in cycle R+1. Throughput is one request in flight.
- rsp_valid high with rsp_ready low: hold indefinitely; no new request is accepted.

## Test plan
- BITLEN=16, e=0x0011, n=0xFFF1, accept at T: exp_e_idx=4, exp_start high only at T+13. Stop pulse with exp_ans=0x1234 two cycles high at T+40: rsp_valid at T+41, rsp_ans=0x1234, rsp_err=0, rsp_cycles=27.
- BITLEN=16, e=0x8001: exp_e_idx=15, exp_start at T+2.
- e=0x0001 and e=0x0000: no exp_start ever; rsp_valid at T+16, rsp_err=1, rsp_ans=0.
- Backpressure: rsp_ready held low 10 cycles, then high. rsp_* stay stable throughout, req_ready=0 until the cycle after the handshake. A req_valid held during RESP is accepted on return to IDLE.
- Stray exp_stop during SCAN and a 3-cycle-high stop in WAIT: only one capture, on the WAIT rising edge.
- rst asserted mid-WAIT, then released: outputs at reset values, req_ready=1. A late exp_stop produces no rsp_valid, and the next request runs normally.
